// File: rtl/latch_q_monitor_if.sv
// Bus bundle for latch_q_monitor: monitored input, control requests, filtered
// level, edge counters, snapshot outputs and FSM debug view.
interface latch_q_monitor_if #(
    parameter int CNT_W = 8
);
    // Snapshot handshake: an edge with rd_req=1 and rd_ack=0 is an accepted read.
    // rd_ack is high for exactly the following cycle, and snap_* is valid from then on.
    // rd_req seen while rd_ack=1 is ignored, so a held request is not re-read back to back.
    logic             q_in;
    logic             clear;
    logic             rd_req;
    logic             q_filt;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic             rd_ack;
    logic [CNT_W-1:0] snap_rise;
    logic [CNT_W-1:0] snap_fall;
    logic             sat;
    logic [1:0]       dbg_state;
    logic [3:0]       dbg_stab;

    modport master (
        output q_in, clear, rd_req,
        input  q_filt, rise_pulse, fall_pulse, rise_cnt, fall_cnt,
               rd_ack, snap_rise, snap_fall, sat, dbg_state, dbg_stab
    );

    modport slave (
        input  q_in, clear, rd_req,
        output q_filt, rise_pulse, fall_pulse, rise_cnt, fall_cnt,
               rd_ack, snap_rise, snap_fall, sat, dbg_state, dbg_stab
    );
endinterface

// File: rtl/latch_q_monitor.sv
// Synchronizes and debounces an asynchronous latch output, counts accepted
// rising/falling edges with saturation, and supports a clear-on-read snapshot.
module latch_q_monitor #(
    parameter int CNT_W         = 8,
    parameter int STABLE_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    latch_q_monitor_if.slave   bus
);
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } state_t;

    localparam logic [3:0]       STAB_LAST = 4'(STABLE_CYCLES - 1);
    localparam bit               DIRECT    = (STABLE_CYCLES == 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             sync1;
    logic             q_sync;
    state_t           state;
    logic [3:0]       stab;
    logic             rise_pulse_r;
    logic             fall_pulse_r;
    logic [CNT_W-1:0] rise_cnt_r;
    logic [CNT_W-1:0] fall_cnt_r;
    logic [CNT_W-1:0] snap_rise_r;
    logic [CNT_W-1:0] snap_fall_r;
    logic             rd_ack_r;
    logic             sat_r;

    logic             rise_ev;
    logic             fall_ev;
    logic             rd_take;
    logic             cnt_zero;
    logic [CNT_W-1:0] rise_base;
    logic [CNT_W-1:0] fall_base;
    logic [CNT_W-1:0] rise_next;
    logic [CNT_W-1:0] fall_next;
    logic             sat_next;

    // Accepted-edge decode: the edge on which the FSM commits to the new level.
    assign rise_ev = q_sync &&
                     (((state == LOW) && DIRECT) ||
                      ((state == RISE_PEND) && (stab == STAB_LAST)));
    assign fall_ev = !q_sync &&
                     (((state == HIGH) && DIRECT) ||
                      ((state == FALL_PEND) && (stab == STAB_LAST)));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            q_sync <= 1'b0;
        end else begin
            sync1  <= bus.q_in;
            q_sync <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOW;
            stab         <= 4'd0;
            rise_pulse_r <= 1'b0;
            fall_pulse_r <= 1'b0;
        end else begin
            rise_pulse_r <= rise_ev;
            fall_pulse_r <= fall_ev;
            case (state)
                LOW: begin
                    if (q_sync) begin
                        if (DIRECT) begin
                            state <= HIGH;
                            stab  <= 4'd0;
                        end else begin
                            state <= RISE_PEND;
                            stab  <= 4'd1;
                        end
                    end
                end
                RISE_PEND: begin
                    if (!q_sync) begin
                        state <= LOW;
                        stab  <= 4'd0;
                    end else if (stab == STAB_LAST) begin
                        state <= HIGH;
                        stab  <= 4'd0;
                    end else begin
                        stab <= stab + 4'd1;
                    end
                end
                HIGH: begin
                    if (!q_sync) begin
                        if (DIRECT) begin
                            state <= LOW;
                            stab  <= 4'd0;
                        end else begin
                            state <= FALL_PEND;
                            stab  <= 4'd1;
                        end
                    end
                end
                default: begin
                    if (q_sync) begin
                        state <= HIGH;
                        stab  <= 4'd0;
                    end else if (stab == STAB_LAST) begin
                        state <= LOW;
                        stab  <= 4'd0;
                    end else begin
                        stab <= stab + 4'd1;
                    end
                end
            endcase
        end
    end

    // A clear (explicit or by read) zeroes the base first, so a coincident
    // edge still lands as a count of 1 and never leaks into the snapshot.
    always_comb begin
        rd_take   = bus.rd_req && !rd_ack_r;
        cnt_zero  = bus.clear || rd_take;
        rise_base = cnt_zero ? '0 : rise_cnt_r;
        fall_base = cnt_zero ? '0 : fall_cnt_r;
        rise_next = rise_base;
        fall_next = fall_base;
        sat_next  = cnt_zero ? 1'b0 : sat_r;
        if (rise_ev) begin
            if (rise_base == CNT_MAX) sat_next  = 1'b1;
            else                      rise_next = rise_base + 1'b1;
        end
        if (fall_ev) begin
            if (fall_base == CNT_MAX) sat_next  = 1'b1;
            else                      fall_next = fall_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_cnt_r  <= '0;
            fall_cnt_r  <= '0;
            snap_rise_r <= '0;
            snap_fall_r <= '0;
            rd_ack_r    <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            rise_cnt_r <= rise_next;
            fall_cnt_r <= fall_next;
            sat_r      <= sat_next;
            rd_ack_r   <= rd_take;
            if (rd_take) begin
                snap_rise_r <= rise_cnt_r;
                snap_fall_r <= fall_cnt_r;
            end
        end
    end

    assign bus.q_filt     = (state == HIGH) || (state == FALL_PEND);
    assign bus.rise_pulse = rise_pulse_r;
    assign bus.fall_pulse = fall_pulse_r;
    assign bus.rise_cnt   = rise_cnt_r;
    assign bus.fall_cnt   = fall_cnt_r;
    assign bus.rd_ack     = rd_ack_r;
    assign bus.snap_rise  = snap_rise_r;
    assign bus.snap_fall  = snap_fall_r;
    assign bus.sat        = sat_r;
    assign bus.dbg_state  = state;
    assign bus.dbg_stab   = stab;
endmodule

// File: doc/latch_q_monitor.md
LATCH_Q_MONITOR -- requirements
Module: latch_q_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the edge counters.
REQ-002 SHALL have parameter STABLE_CYCLES, default 3 (legal 1..15), consecutive synchronized samples required to accept a level change.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port q_in, input, 1, asynchronous latch output q being monitored.
REQ-006 SHALL have port clear, input, 1, synchronous counter clear request.
REQ-007 SHALL have port rd_req, input, 1, snapshot read request.
REQ-008 SHALL have port q_filt, output, 1, filtered, synchronized level of q_in.
REQ-009 SHALL have port rise_pulse, output, 1, one-cycle pulse on an accepted 0->1 change.
REQ-010 SHALL have port fall_pulse, output, 1, one-cycle pulse on an accepted 1->0 change.
REQ-011 SHALL have port rise_cnt, output, CNT_W, live count of accepted rises.
REQ-012 SHALL have port fall_cnt, output, CNT_W, live count of accepted falls.
REQ-013 SHALL have port rd_ack, output, 1, one-cycle acknowledgement that the snapshot is valid.
REQ-014 SHALL have port snap_rise, output, CNT_W, rise_cnt captured at read.
REQ-015 SHALL have port snap_fall, output, CNT_W, fall_cnt captured at read.
REQ-016 SHALL have port sat, output, 1, sticky flag: either counter has saturated.

Function
REQ-017 SHALL pass q_in through a 2-flop synchronizer; the second flop is q_sync, and no other logic SHALL read q_in.
REQ-018 SHALL implement FSM states LOW, RISE_PEND, HIGH, FALL_PEND, with a stability counter stab.
REQ-019 SHALL move LOW->RISE_PEND with stab=1 when q_sync=1; HIGH->FALL_PEND with stab=1 when q_sync=0.
REQ-020 SHALL in RISE_PEND: if q_sync=0, return to LOW with no count; otherwise increment stab. It SHALL enter HIGH on the edge at which q_sync has been 1 for STABLE_CYCLES consecutive samples.
REQ-021 SHALL apply the mirror of REQ-020 to FALL_PEND with respect to HIGH/LOW.
REQ-022 SHALL, with STABLE_CYCLES=1, transition LOW->HIGH (or HIGH->LOW) directly on the first differing sample.
REQ-023 SHALL drive q_filt=1 exactly in states HIGH and FALL_PEND.
REQ-024 SHALL have total latency from the first clk edge sampling a stable new q_in level to q_filt change and pulse equal to STABLE_CYCLES+1 edges (4 at default).
REQ-025 SHALL register rise_pulse/fall_pulse and assert them for exactly one cycle, coincident with the q_filt change.
REQ-026 SHALL increment rise_cnt (fall_cnt) on the same edge the pulse asserts.
REQ-027 SHALL saturate the counters at 2^CNT_W-1 with no wrap-around; an increment attempt at the maximum SHALL set sat.
REQ-028 SHALL, when rd_req=1 and rd_ack=0 on an edge, load snap_rise/snap_fall with the pre-edge counter values, assert rd_ack for one cycle, and clear both counters and sat.
REQ-029 SHALL ignore rd_req while rd_ack=1; snap values SHALL hold until the next accepted read.
REQ-030 SHALL zero both counters and sat when clear=1; snaps are unaffected.
REQ-031 SHALL resolve a count event coinciding with a clear or read clear so the affected counter becomes 1; the event is never lost, and the snapshot excludes it.
REQ-032 SHALL not change FSM state or q_filt on clear or read.

Reset
REQ-033 SHALL, on reset=1 at a clk edge, set both synchronizer flops to 0, state LOW, stab=0, and all outputs to 0.
REQ-034 SHALL give reset priority over all other inputs; reset during RISE_PEND/HIGH SHALL abort to LOW with no pulse.
REQ-035 SHALL, after reset release with q_in=1, report the rise per REQ-024 as a counted edge.

Verification
REQ-036 SHALL cover: reset, q_in held 1 from edge 0 -> q_filt=1 and rise_pulse for one cycle at edge 4; rise_cnt=1.
REQ-037 SHALL cover: q_in=1 for 2 cycles then 0 (default params) -> q_filt stays 0, no pulse, rise_cnt=0.
REQ-038 SHALL cover: 5 full accepted high/low cycles, then rd_req -> rd_ack next cycle; snap_rise=5, snap_fall=5; counters read 0.
REQ-039 SHALL cover: CNT_W=2 with 4 accepted rises -> rise_cnt=3, sat=1; clear -> rise_cnt=0, sat=0.
REQ-040 SHALL cover: rd_req on the same edge as an accepted rise with rise_cnt=2 -> snap_rise=2, rise_cnt=1.
REQ-041 SHALL cover: reset asserted in FALL_PEND -> next cycle all outputs 0, state LOW, no fall_pulse.
